// File: rtl/viterbi_k3_stream.sv
// viterbi_k3_stream: hard-decision Viterbi decoder for the rate-1/2, K=3
// (4-state) convolutional code. Coded bits arrive serially (c0 then c1 per
// trellis step); ACS runs on the second bit of each pair with register-exchange
// survivors. A FLUSH cycle unloads the state-0 survivor, then the decoded bits
// leave serially under a valid/ready handshake.
module viterbi_k3_stream #(
    parameter int         DATA_BITS = 5,
    parameter logic [2:0] G0        = 3'b101,
    parameter logic [2:0] G1        = 3'b111,
    parameter int         MW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_bit,
    output logic          out_last,
    input  logic          out_ready,
    output logic [MW-1:0] frame_errs
);

    localparam int STEPS = DATA_BITS + 2;
    localparam int SW    = $clog2(STEPS);
    localparam int OW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [MW-1:0] PM_MAX = '1;

    typedef enum logic [1:0] {RECV, FLUSH, SEND} state_t;

    typedef struct packed {
        logic [MW-1:0]    pm;
        logic [STEPS-1:0] surv;
    } acs_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        step;
    logic                 half;
    logic                 c0_q;
    logic [MW-1:0]        pm   [4];
    logic [STEPS-1:0]     surv [4];
    acs_t                 acs_res [4];
    logic [DATA_BITS-1:0] out_sr;
    logic [OW-1:0]        out_idx;
    logic                 in_xfer;
    logic                 last_bit;

    // Hamming distance between received pair and the branch's expected pair.
    function automatic logic [1:0] branch_metric(input logic u, input logic [1:0] s,
                                                 input logic r0, input logic r1);
        logic e0, e1;
        e0 = ^(G0 & {u, s});
        e1 = ^(G1 & {u, s});
        return {1'b0, r0 ^ e0} + {1'b0, r1 ^ e1};
    endfunction

    // Path-metric add that sticks at all-ones instead of wrapping.
    function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [1:0] b);
        logic [MW:0] sum;
        sum = {1'b0, a} + {{(MW-1){1'b0}}, b};
        return sum[MW] ? PM_MAX : sum[MW-1:0];
    endfunction

    // One add-compare-select for next state ns = {u, s1}; predecessors {s1,0} and {s1,1}.
    function automatic acs_t acs(input logic [1:0] ns,
                                 input logic [MW-1:0] pm0, input logic [MW-1:0] pm1,
                                 input logic [STEPS-1:0] sv0, input logic [STEPS-1:0] sv1,
                                 input logic r0, input logic r1, input logic [SW-1:0] stp);
        logic [MW-1:0] cand0, cand1;
        acs_t          r;
        cand0 = sat_add(pm0, branch_metric(ns[1], {ns[0], 1'b0}, r0, r1));
        cand1 = sat_add(pm1, branch_metric(ns[1], {ns[0], 1'b1}, r0, r1));
        // Ties go to the {s1,0} predecessor.
        if (cand1 < cand0) begin
            r.pm   = cand1;
            r.surv = sv1;
        end else begin
            r.pm   = cand0;
            r.surv = sv0;
        end
        r.surv[stp] = ns[1];
        // Tail steps carry forced zero inputs, so u=1 states are unreachable.
        if (ns[1] && (stp >= SW'(DATA_BITS))) r.pm = PM_MAX;
        return r;
    endfunction

    assign in_xfer  = in_valid & in_ready;
    assign last_bit = (out_idx == OW'(DATA_BITS - 1));
    assign out_bit  = out_sr[0];

    // Evaluate all four ACS units from the current metrics and received pair.
    always_comb begin
        for (int ns = 0; ns < 4; ns++) begin
            acs_res[ns] = acs(2'(ns), pm[2*(ns%2)], pm[2*(ns%2)+1],
                              surv[2*(ns%2)], surv[2*(ns%2)+1], c0_q, in_bit, step);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) state <= RECV;
        else        state <= state_nxt;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid && half && (step == SW'(STEPS - 1))) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_last  = last_bit;
                if (out_ready && last_bit) state_nxt = RECV;
            end
            default: state_nxt = RECV;
        endcase
    end

    // Trellis datapath: pair capture, ACS update, frame unload and output shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step       <= '0;
            half       <= 1'b0;
            c0_q       <= 1'b0;
            out_sr     <= '0;
            out_idx    <= '0;
            frame_errs <= '0;
            // NOTE: survivors are a handful of flops, not a RAM, so they are
            // reset along with everything else for deterministic frames.
            for (int s = 0; s < 4; s++) begin
                pm[s]   <= (s == 0) ? '0 : PM_MAX;
                surv[s] <= '0;
            end
        end else begin
            case (state)
                RECV: begin
                    if (in_xfer && !half) begin
                        c0_q <= in_bit;
                        half <= 1'b1;
                    end else if (in_xfer) begin
                        half <= 1'b0;
                        step <= step + 1'b1;
                        for (int s = 0; s < 4; s++) begin
                            pm[s]   <= acs_res[s].pm;
                            surv[s] <= acs_res[s].surv;
                        end
                    end
                end
                FLUSH: begin
                    out_sr     <= surv[0][DATA_BITS-1:0];
                    frame_errs <= pm[0];
                    out_idx    <= '0;
                    step       <= '0;
                    for (int s = 0; s < 4; s++) pm[s] <= (s == 0) ? '0 : PM_MAX;
                end
                SEND: begin
                    if (out_ready) begin
                        out_sr  <= out_sr >> 1;
                        out_idx <= last_bit ? '0 : out_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_k3_stream.sv
// Testbench for viterbi_k3_stream: table-driven frames on a DATA_BITS=5 decoder,
// plus hand-written sequences for reset mid-input, reset mid-output and a
// gappy all-zero frame on a DATA_BITS=8 decoder.
module tb_viterbi_k3_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_bit, out_ready, sel;

    logic       in_ready_a, out_valid_a, out_bit_a, out_last_a;
    logic [4:0] frame_errs_a;
    logic       in_ready_b, out_valid_b, out_bit_b, out_last_b;
    logic [4:0] frame_errs_b;
    logic       in_valid_a, in_valid_b;

    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;

    viterbi_k3_stream dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_bit(in_bit),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_bit(out_bit_a),
        .out_last(out_last_a), .out_ready(out_ready), .frame_errs(frame_errs_a)
    );

    viterbi_k3_stream #(.DATA_BITS(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_bit(in_bit),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_bit(out_bit_b),
        .out_last(out_last_b), .out_ready(out_ready), .frame_errs(frame_errs_b)
    );

    // Outputs of whichever decoder is under test.
    logic       ir, ov, ob, ol;
    logic [4:0] fe;
    assign ir = sel ? in_ready_b   : in_ready_a;
    assign ov = sel ? out_valid_b  : out_valid_a;
    assign ob = sel ? out_bit_b    : out_bit_a;
    assign ol = sel ? out_last_b   : out_last_a;
    assign fe = sel ? frame_errs_b : frame_errs_a;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting on the decoder", name);
    endtask

    // Encoded message 1,0,1,1,0 (+tail): 1,1,0,1,0,0,1,0,1,0,1,1,0,0 (bit i = stream index i).
    localparam logic [13:0] FRAME_A = 14'b00110101001011;
    localparam logic [4:0]  DATA_A  = 5'b01101;
    // Encoded message 0,1,1,0,1 (+tail): 0,0,1,1,1,0,1,0,0,0,0,1,1,1.
    localparam logic [13:0] FRAME_B = 14'b11100001011100;
    localparam logic [4:0]  DATA_B  = 5'b10110;

    typedef struct {
        string       name;
        logic [13:0] stream;
        logic [4:0]  exp_out;
        logic [4:0]  exp_errs;
        bit          bp;
    } vec_t;

    vec_t tbl [6];

    // Feed n coded bits; optionally insert random idle gaps with junk on in_bit.
    task automatic drive_frame(input logic [31:0] bits, input int n, input bit gaps,
                               output bit early_out);
        int g;
        int guard;
        early_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                if (ov) early_out = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = bits[i];
            if (ov) early_out = 1'b1;
            guard = 0;
            while (!ir && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                timeout("in_ready");
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect n decoded bits, optionally with 1,0,0,1 backpressure, then check frame_errs.
    task automatic recv_frame(input string name, input logic [31:0] exp_bits, input int n,
                              input logic [31:0] exp_errs, input bit bp);
        int         got;
        int         cyc;
        int         k;
        bit         stalled;
        logic       prev_bit, prev_last;
        logic [3:0] pat;
        got = 0; cyc = 0; k = 0; stalled = 1'b0; pat = 4'b1001;
        prev_bit = 1'b0; prev_last = 1'b0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = bp ? pat[k % 4] : 1'b1;
            if (ov) begin
                check({name, " in_ready low in SEND"}, 32'(ir), 32'd0);
                if (stalled) begin
                    check({name, " held out_bit"}, 32'(ob), 32'(prev_bit));
                    check({name, " held out_last"}, 32'(ol), 32'(prev_last));
                end
                if (out_ready) begin
                    check($sformatf("%s out_bit[%0d]", name, got), 32'(ob), 32'(exp_bits[got]));
                    check($sformatf("%s out_last[%0d]", name, got), 32'(ol), 32'(got == n - 1));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    prev_bit  = ob;
                    prev_last = ol;
                end
                k++;
            end
        end
        if (got < n) timeout({name, " output"});
        @(negedge clk);
        out_ready = 1'b1;
        check({name, " in_ready after frame"}, 32'(ir), 32'd1);
        check({name, " out_valid after frame"}, 32'(ov), 32'd0);
        check({name, " frame_errs"}, 32'(fe), exp_errs);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " in_ready"}, 32'(ir), 32'd1);
        check({name, " out_valid"}, 32'(ov), 32'd0);
        check({name, " out_bit"}, 32'(ob), 32'd0);
        check({name, " out_last"}, 32'(ol), 32'd0);
        check({name, " frame_errs"}, 32'(fe), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit eo;
        int guard;

        tbl[0] = '{"clean_a",   FRAME_A,                                DATA_A, 5'd0, 1'b0};
        tbl[1] = '{"clean_b",   FRAME_B,                                DATA_B, 5'd0, 1'b0};
        tbl[2] = '{"err1_b",    FRAME_B ^ (14'd1 << 7),                 DATA_B, 5'd1, 1'b0};
        tbl[3] = '{"err1_a",    FRAME_A ^ (14'd1 << 4),                 DATA_A, 5'd1, 1'b0};
        tbl[4] = '{"bp_a",      FRAME_A,                                DATA_A, 5'd0, 1'b1};
        tbl[5] = '{"err2_a",    FRAME_A ^ (14'd1 << 0) ^ (14'd1 << 9),  DATA_A, 5'd2, 1'b0};

        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1; sel = 1'b0;
        #7;
        check_reset_outputs("reset_a");
        check("reset in_ready_b", 32'(in_ready_b), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive_frame(32'(tbl[i].stream), 14, 1'b0, eo);
            recv_frame(tbl[i].name, 32'(tbl[i].exp_out), 5, 32'(tbl[i].exp_errs), tbl[i].bp);
        end

        // Reset after 7 input bits (frame_errs is 2 from the previous frame).
        drive_frame(32'(FRAME_A), 7, 1'b0, eo);
        #3 reset = 1'b0;
        #1 check_reset_outputs("reset_mid_in");
        @(negedge clk);
        reset = 1'b1;
        drive_frame(32'(FRAME_A), 14, 1'b0, eo);
        recv_frame("after_reset_in", 32'(DATA_A), 5, 32'd0, 1'b0);

        // Reset during SEND, then a different frame must decode cleanly.
        drive_frame(32'(FRAME_B ^ (14'd1 << 2)), 14, 1'b0, eo);
        guard = 0;
        while (!ov && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout("wait SEND");
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_mid_out");
        @(negedge clk);
        reset = 1'b1;
        drive_frame(32'(FRAME_A), 14, 1'b0, eo);
        recv_frame("after_reset_out", 32'(DATA_A), 5, 32'd0, 1'b0);

        // Gappy all-zero 20-bit frame on the DATA_BITS=8 decoder.
        sel = 1'b1;
        drive_frame(32'd0, 20, 1'b1, eo);
        check("gappy no early output", 32'(eo), 32'd0);
        recv_frame("gappy_b8", 32'd0, 8, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_k3_stream.md
Name: viterbi_k3_stream

Overview:
- Parametrised successor to the team's fixed 7-bit, two-clock Viterbi decoder.
- Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 (4-state) convolutional code, with generator polynomials and frame length set by parameters.
- Serial coded bits arrive under a valid/ready handshake on one clock. Decoded data bits leave serially under a second valid/ready handshake, with the winning path's Hamming distance reported per frame.
- Sits between the channel bit slicer and the frame sink in the receive chain.

Parameters:
DATA_BITS, 5, information bits per frame; the frame carries DATA_BITS+2 trellis steps (2 zero tail bits); range 1..30
G0, 3'b101, generator for first coded bit; bit2 taps u_t, bit1 taps u_t-1, bit0 taps u_t-2
G1, 3'b111, generator for second coded bit; same tap order
MW, 5, path-metric width; must satisfy 2^MW-1 >= 2*(DATA_BITS+2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  in_bit valid this cycle
in_bit  in  1  received coded bit; per step c0 first, then c1
in_ready  out  1  decoder accepts in_bit
out_valid  out  1  out_bit valid
out_bit  out  1  decoded data bit, u_0 first
out_last  out  1  marks final data bit of the frame
out_ready  in  1  sink accepts out_bit
frame_errs  out  MW  final state-0 path metric (Hamming distance to best codeword); held until the next frame completes

Behaviour:
- Encoder model: state s = {u_t-1, u_t-2}; c0 = parity(G0 & {u_t, s}), c1 = parity(G1 & {u_t, s}); start state and end state are 00.
- Reset values (asynchronous, any time, including mid-frame or mid-output):
  - Outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0, frame_errs=0.
  - Internals: state machine to RECV, step counter 0, pair-half flag 0, metrics: state 0 = 0, states 1-3 = all-ones.
  - A partial frame is discarded.
- State machine:
  - RECV: in_ready=1.
    - An input transfer occurs when in_valid & in_ready.
    - The first transfer of a step latches c0; the second performs ACS in the same cycle.
    - ACS registers four new metrics and updates four survivor registers of DATA_BITS+2 bits (register exchange; the decided bit is written at index = step).
    - Step counter increments per completed pair.
    - After step DATA_BITS+1 completes, go to FLUSH.
  - FLUSH: one cycle, in_ready=0.
    - Copy the state-0 survivor's low DATA_BITS bits into the output shift register.
    - Load frame_errs from the state-0 metric.
    - Reinitialise metrics and the step counter, then go to SEND.
  - SEND: in_ready=0, out_valid=1.
    - out_bit = current bit; out_last=1 on bit index DATA_BITS-1.
    - Advance only when out_ready=1.
    - The transfer with out_last returns to RECV on the next cycle.
- ACS:
  - Branch metric = (c0 XOR expected c0) + (c1 XOR expected c1), range 0..2.
  - For next state {u, s1}, the predecessors are {s1,0} and {s1,1}.
  - Each candidate = predecessor metric + branch metric, saturating at 2^MW-1.
  - The smaller candidate wins; on a tie the predecessor {s1,0} wins.
  - Tail steps (step >= DATA_BITS): only u=0 transitions are legal; states with u=1 are forced to all-ones.
- Gaps in in_valid: any cycles allowed between bits, including between c0 and c1; no state changes while idle.
- Output hold: out_bit and out_last stay stable while out_valid=1 and out_ready=0.
- Input pipelining: in_bit is accepted in the FLUSH→RECV cycle only from the first RECV cycle onward (no overlap with SEND).

Test Plan:
- Error-free frame: defaults, stream 1,1,0,1,0,0,1,0,1,0,1,1,0,0 with in_valid held high and out_ready=1 → out 1,0,1,1,0 with out_last on the 5th bit; frame_errs=0.
- Single error: same stream with bit index 4 flipped to 1 → out 1,0,1,1,0; frame_errs=1.
- Two spaced errors: flip indices 0 and 9 → out 1,0,1,1,0; frame_errs=2.
- Backpressure: out_ready toggled 1,0,0,1,… during SEND → each bit held stable while stalled; in_ready=0 until out_last transfers, then in_ready=1.
- Reset mid-operation: reset asserted after 7 input bits, then a full error-free frame → only that frame's data out; frame_errs=0.
- Gappy input with DATA_BITS=8: random in_valid gaps, all-zero 20-bit stream → eight 0 bits out; frame_errs=0; no output before the 20th input bit.
